// File: rtl/gate_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gate_pipe_if
// Description : Handshake bundle for gate_pipe. Carries the upstream
//               valid/ready + op/operands side and the downstream
//               valid/ready + result side.
//               master : drives in_valid/op/operands/out_ready
//               slave  : drives in_ready/out_valid/result (the pipe itself)
// Parameters  : WIDTH  - operand/result width
//               NUM_IN - number of packed operands
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              op;
    logic [NUM_IN*WIDTH-1:0] operands;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        result;

    modport master (
        output in_valid, op, operands, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operands, out_ready,
        output in_ready, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/gate_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gate_pipe
// Description : Two-stage pipelined N-input bitwise logic unit.
//               op: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                   6 NOT (~operand0), 7 PASS (operand0)
//               S1 registers op/operands, S2 registers the result.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous reset, active-high
//               bus       - gate_pipe_if.slave (in/out handshakes, data)
//               txn_count - output transfer count, saturating (optional)
// Option      : GATE_PIPE_STATS_EN adds the txn_count port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    gate_pipe_if.slave       bus
`ifdef GATE_PIPE_STATS_EN
    ,
    output logic [15:0]      txn_count
`endif
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_NOT  = 3'd6;

    logic                    s1_valid_q;
    logic [2:0]              s1_op_q;
    logic [NUM_IN*WIDTH-1:0] s1_opnd_q;
    logic                    s2_valid_q;
    logic [WIDTH-1:0]        s2_result_q;

    logic                    w_in_ready;
    logic                    w_in_fire;
    logic                    w_s2_load;
    logic [WIDTH-1:0]        w_and;
    logic [WIDTH-1:0]        w_or;
    logic [WIDTH-1:0]        w_xor;
    logic [WIDTH-1:0]        w_opnd0;
    logic [WIDTH-1:0]        result_d;

    // S2 advances when it is empty or being drained this cycle.
    assign w_s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
    // S1 can take a new item whenever it is empty or moving into S2;
    // this is the only combinational path from out_ready.
    assign w_in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;

    assign w_opnd0 = s1_opnd_q[WIDTH-1:0];

    // N-way reductions across all operands held in S1.
    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_and = w_and & s1_opnd_q[i*WIDTH +: WIDTH];
            w_or  = w_or  | s1_opnd_q[i*WIDTH +: WIDTH];
            w_xor = w_xor ^ s1_opnd_q[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result_d = w_opnd0;
        case (s1_op_q)
            c_OP_AND:  result_d = w_and;
            c_OP_OR:   result_d = w_or;
            c_OP_XOR:  result_d = w_xor;
            c_OP_NAND: result_d = ~w_and;
            c_OP_NOR:  result_d = ~w_or;
            c_OP_XNOR: result_d = ~w_xor;
            c_OP_NOT:  result_d = ~w_opnd0;
            default:   result_d = w_opnd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_opnd_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
        end else begin
            // Data only moves on a real transfer so S1 stays clean
            // while idle.
            if (w_in_fire) begin
                s1_op_q   <= bus.op;
                s1_opnd_q <= bus.operands;
            end
            if (w_in_ready) begin
                s1_valid_q <= bus.in_valid;
            end
            if (w_s2_load) begin
                s2_result_q <= result_d;
                s2_valid_q  <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid_q  <= 1'b0;
            end
        end
    end

`ifdef GATE_PIPE_STATS_EN
    logic [15:0] txn_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count_q <= '0;
        end else if (s2_valid_q && bus.out_ready && (txn_count_q != 16'hFFFF)) begin
            txn_count_q <= txn_count_q + 16'd1;
        end
    end

    assign txn_count = txn_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gate_pipe
// Description : Testbench for gate_pipe. Three instances cover
//               WIDTH=1/NUM_IN=2, WIDTH=8/NUM_IN=3 and WIDTH=8/NUM_IN=2.
//               Each accepted input pushes its expected result; each
//               output transfer pops and compares in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_pipe_if #(.WIDTH(1), .NUM_IN(2)) if0 ();
    gate_pipe_if #(.WIDTH(8), .NUM_IN(3)) if1 ();
    gate_pipe_if #(.WIDTH(8), .NUM_IN(2)) if2 ();

`ifdef GATE_PIPE_STATS_EN
    logic [15:0] txn_count0, txn_count1, txn_count2;
`endif

    gate_pipe #(.WIDTH(1), .NUM_IN(2)) u0 (
        .clk (clk), .rst (rst), .bus (if0.slave)
`ifdef GATE_PIPE_STATS_EN
        , .txn_count (txn_count0)
`endif
    );
    gate_pipe #(.WIDTH(8), .NUM_IN(3)) u1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
`ifdef GATE_PIPE_STATS_EN
        , .txn_count (txn_count1)
`endif
    );
    gate_pipe #(.WIDTH(8), .NUM_IN(2)) u2 (
        .clk (clk), .rst (rst), .bus (if2.slave)
`ifdef GATE_PIPE_STATS_EN
        , .txn_count (txn_count2)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_out0 = 0, n_out1 = 0, n_out2 = 0;
    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] exp0, exp1, exp2;
    logic [7:0] e0, e1, e2;

    // Scoreboards: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
        end else begin
            if (if0.in_valid && if0.in_ready) q0.push_back(exp0);
            if (if0.out_valid && if0.out_ready) begin
                n_out0++;
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL sb0_extra: got result=%h, expected no output", if0.result);
                end else begin
                    e0 = q0.pop_front();
                    if ({7'd0, if0.result} !== e0) begin
                        n_err++;
                        $display("FAIL sb0_result: got %h, expected %h", if0.result, e0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else begin
            if (if1.in_valid && if1.in_ready) q1.push_back(exp1);
            if (if1.out_valid && if1.out_ready) begin
                n_out1++;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL sb1_extra: got result=%h, expected no output", if1.result);
                end else begin
                    e1 = q1.pop_front();
                    if (if1.result !== e1) begin
                        n_err++;
                        $display("FAIL sb1_result: got %h, expected %h", if1.result, e1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
        end else begin
            if (if2.in_valid && if2.in_ready) q2.push_back(exp2);
            if (if2.out_valid && if2.out_ready) begin
                n_out2++;
                n_cmp++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL sb2_extra: got result=%h, expected no output", if2.result);
                end else begin
                    e2 = q2.pop_front();
                    if (if2.result !== e2) begin
                        n_err++;
                        $display("FAIL sb2_result: got %h, expected %h", if2.result, e2);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.result !== 1'b0) begin
            n_err++; $display("FAIL reset_d0: got ov=%b ir=%b res=%h, expected 0 1 0", if0.out_valid, if0.in_ready, if0.result);
        end
        n_cmp++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1 || if1.result !== 8'h00) begin
            n_err++; $display("FAIL reset_d1: got ov=%b ir=%b res=%h, expected 0 1 00", if1.out_valid, if1.in_ready, if1.result);
        end
        n_cmp++; if (if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1 || if2.result !== 8'h00) begin
            n_err++; $display("FAIL reset_d2: got ov=%b ir=%b res=%h, expected 0 1 00", if2.out_valid, if2.in_ready, if2.result);
        end
`ifdef GATE_PIPE_STATS_EN
        n_cmp++; if (txn_count2 !== 16'd0) begin
            n_err++; $display("FAIL reset_txn: got %0d, expected 0", txn_count2);
        end
`endif
        step();
    endtask

    // 1-bit AND truth table streamed back to back; out_valid must be
    // high exactly in cycles 2..5.
    task automatic test_and_w1();
        logic [1:0] ab;
        int start;
        start = n_out0;
        if0.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ab = 2'(c);
            if0.in_valid = (c < 4);
            if0.op       = 3'd0;
            if0.operands = ab;
            exp0         = {7'd0, ab[1] & ab[0]};
            @(negedge clk);
            n_cmp++;
            if (if0.out_valid !== ((c >= 2) && (c <= 5))) begin
                n_err++;
                $display("FAIL and_w1_latency: cycle %0d out_valid=%b, expected %b", c, if0.out_valid, ((c >= 2) && (c <= 5)));
            end
            step();
        end
        if0.in_valid = 1'b0;
        n_cmp++; if (n_out0 - start != 4) begin
            n_err++; $display("FAIL and_w1_count: got %0d outputs, expected 4", n_out0 - start);
        end
    endtask

    task automatic test_ops_n3();
        logic [2:0] ops [5] = '{3'd2, 3'd5, 3'd6, 3'd0, 3'd1};
        logic [7:0] exps[5] = '{8'h55, 8'hAA, 8'h5A, 8'h05, 8'hFF};
        int start;
        start = n_out1;
        if1.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if1.in_valid = 1'b1;
            if1.op       = ops[i];
            if1.operands = {8'hFF, 8'h0F, 8'hA5};
            exp1         = exps[i];
            step();
        end
        if1.in_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (n_out1 - start != 5 || q1.size() != 0) begin
            n_err++; $display("FAIL ops_n3_drain: got %0d outputs/%0d pending, expected 5/0", n_out1 - start, q1.size());
        end
    endtask

    task automatic test_ops_n2();
        logic [2:0] ops [8] = '{3'd3, 3'd4, 3'd7, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
        logic [7:0] exps[8] = '{8'hCF, 8'h03, 8'hF0, 8'h30, 8'hFC, 8'hCC, 8'h33, 8'h0F};
        int start;
        start = n_out2;
        if2.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if2.in_valid = 1'b1;
            if2.op       = ops[i];
            if2.operands = {8'h3C, 8'hF0};
            exp2         = exps[i];
            step();
        end
        if2.in_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (n_out2 - start != 8 || q2.size() != 0) begin
            n_err++; $display("FAIL ops_n2_drain: got %0d outputs/%0d pending, expected 8/0", n_out2 - start, q2.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] items[3] = '{8'h11, 8'h22, 8'h33};
        int idx = 0;
        int start;
        logic acc;
        start = n_out2;
        if2.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if2.in_valid = (idx < 3);
            if2.op       = 3'd7;
            if2.operands = {8'hC3, (idx < 3) ? items[idx] : 8'h00};
            exp2         = (idx < 3) ? items[idx] : 8'h00;
            @(negedge clk);
            acc = if2.in_valid && if2.in_ready;
            if (c >= 2) begin
                n_cmp++;
                if (if2.out_valid !== 1'b1 || if2.result !== 8'h11) begin
                    n_err++;
                    $display("FAIL bp_stall_hold: cycle %0d ov=%b res=%h, expected 1 11", c, if2.out_valid, if2.result);
                end
            end
            step();
            if (acc) idx++;
        end
        n_cmp++; if (idx != 2 || if2.in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_full: accepted=%0d in_ready=%b, expected 2 0", idx, if2.in_ready);
        end
        if2.out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            if2.in_valid = 1'b1;
            if2.operands = {8'hC3, items[idx]};
            exp2         = items[idx];
            @(negedge clk);
            acc = if2.in_valid && if2.in_ready;
            step();
            if (acc) idx++;
        end
        if2.in_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (idx != 3 || n_out2 - start != 3 || q2.size() != 0) begin
            n_err++; $display("FAIL bp_drain: accepted=%0d outputs=%0d pending=%0d, expected 3 3 0", idx, n_out2 - start, q2.size());
        end
    endtask

    task automatic test_reset_midflight();
        int start;
        if2.out_ready = 1'b0;
        if2.op        = 3'd7;
        if2.in_valid  = 1'b1; if2.operands = {8'h00, 8'h44}; exp2 = 8'h44;
        step();
        if2.operands  = {8'h00, 8'h55}; exp2 = 8'h55;
        step();
        if2.in_valid  = 1'b0;
        @(negedge clk);
        n_cmp++; if (if2.out_valid !== 1'b1 || if2.in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_fill: ov=%b ir=%b, expected 1 0", if2.out_valid, if2.in_ready);
        end
        step();
        // Offer an item during the reset cycle; it must be ignored.
        rst = 1'b1;
        if2.in_valid = 1'b1; if2.operands = {8'h00, 8'h66}; exp2 = 8'h66;
        step();
        rst = 1'b0;
        if2.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (if2.out_valid !== 1'b0 || if2.result !== 8'h00 || if2.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_state: ov=%b res=%h ir=%b, expected 0 00 1", if2.out_valid, if2.result, if2.in_ready);
        end
        step();
        start = n_out2;
        if2.out_ready = 1'b1;
        repeat (6) step();
        n_cmp++; if (n_out2 != start) begin
            n_err++; $display("FAIL rst_mid_stale: got %0d outputs after reset, expected 0", n_out2 - start);
        end
    endtask

    task automatic test_stats();
`ifdef GATE_PIPE_STATS_EN
        int idx = 0;
        int start;
        logic acc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = n_out2;
        if2.op = 3'd7;
        for (int c = 0; c < 12; c++) begin
            if2.in_valid  = (idx < 5);
            if2.operands  = {8'h00, 8'(idx + 1)};
            exp2          = 8'(idx + 1);
            if2.out_ready = (c != 3);
            @(negedge clk);
            acc = if2.in_valid && if2.in_ready;
            step();
            if (acc) idx++;
        end
        if2.in_valid  = 1'b0;
        if2.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (txn_count2 !== 16'd5 || n_out2 - start != 5) begin
            n_err++; $display("FAIL stats_count: txn_count=%0d outputs=%0d, expected 5 5", txn_count2, n_out2 - start);
        end
        step();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        if0.in_valid = 1'b0; if0.op = '0; if0.operands = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.op = '0; if1.operands = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.op = '0; if2.operands = '0; if2.out_ready = 1'b0;
        exp0 = '0; exp1 = '0; exp2 = '0;
        test_reset();
        test_and_w1();
        test_ops_n3();
        test_ops_n2();
        test_backpressure();
        test_reset_midflight();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
